// File: rtl/filter_pipe.sv
// filter_pipe: chain of STAGES registered shift/parity stages with a valid/ready
// handshake on both sides and an occupancy counter.
// Each stage shifts its data left by one, taking the incoming parity as the new
// LSB and emitting the old MSB as the new parity. The net effect is a rotate-left
// by STAGES of the word {data, parity}.
// Optional feature: define FILTER_PIPE_FLUSH_EN to add the io_flush port, which
// drops every in-flight beat on the next clock edge.

module filter_pipe #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned STAGES     = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [DATA_WIDTH-1:0]          io_x_data,
  input  logic                           io_x_parity,
  input  logic                           io_x_valid,
  output logic                           io_x_ready,
  output logic [DATA_WIDTH-1:0]          io_y_data,
  output logic                           io_y_parity,
  output logic                           io_y_valid,
  input  logic                           io_y_ready,
`ifdef FILTER_PIPE_FLUSH_EN
  input  logic                           io_flush,
`endif
  output logic [$clog2(STAGES+1)-1:0]    io_count
);

  localparam int unsigned CountW = $clog2(STAGES + 1);

  // Per-stage state
  logic [DATA_WIDTH-1:0] data_q   [STAGES];
  logic [DATA_WIDTH-1:0] data_d   [STAGES];
  logic [STAGES-1:0]     parity_q, parity_d;
  logic [STAGES-1:0]     valid_q,  valid_d;

  // Per-stage load sources: stage 0 reads the input port, stage i reads stage i-1
  logic [DATA_WIDTH-1:0] src_data [STAGES];
  logic [STAGES-1:0]     src_parity;
  logic [STAGES-1:0]     src_valid;

  logic [STAGES-1:0]     ready;
  logic                  ready_acc;
  logic [CountW-1:0]     count_q, count_d;
  logic                  flush;
  logic                  in_fire;
  logic                  out_fire;

`ifdef FILTER_PIPE_FLUSH_EN
  assign flush = io_flush;
`else
  assign flush = 1'b0;
`endif

  // Ready chain: a stage can load if it is empty or everything downstream moves.
  // Built as a running OR from the output end to avoid a self-referencing vector.
  always_comb begin
    ready_acc = io_y_ready;
    ready     = '0;
    for (int i = int'(STAGES) - 1; i >= 0; i--) begin
      ready_acc = ready_acc | ~valid_q[i];
      ready[i]  = ready_acc;
    end
  end

  // Handshake outputs; flush masks both sides so no transfer can occur.
  always_comb begin
    io_x_ready  = ready[0] & ~flush;
    io_y_valid  = valid_q[STAGES-1] & ~flush;
    io_y_data   = data_q[STAGES-1];
    io_y_parity = parity_q[STAGES-1];
    io_count    = count_q;
    in_fire     = io_x_valid & io_x_ready;
    out_fire    = io_y_valid & io_y_ready;
  end

  // Load sources for every stage.
  always_comb begin
    src_data[0]   = io_x_data;
    src_parity[0] = io_x_parity;
    src_valid[0]  = io_x_valid & ~flush;
    for (int i = 1; i < int'(STAGES); i++) begin
      src_data[i]   = data_q[i-1];
      src_parity[i] = parity_q[i-1];
      src_valid[i]  = valid_q[i-1];
    end
  end

  // Stage next-state: hold unless ready; apply the shift/parity transform on load.
  always_comb begin
    for (int i = 0; i < int'(STAGES); i++) begin
      valid_d[i]  = valid_q[i];
      data_d[i]   = data_q[i];
      parity_d[i] = parity_q[i];
      if (ready[i]) begin
        valid_d[i] = src_valid[i];
        // Data only moves with a valid beat so bubbles do not toggle the datapath
        if (src_valid[i]) begin
          data_d[i]   = {src_data[i][DATA_WIDTH-2:0], src_parity[i]};
          parity_d[i] = src_data[i][DATA_WIDTH-1];
        end
      end
      if (flush) begin
        valid_d[i] = 1'b0;
      end
    end
  end

  // Occupancy: tracks the number of valid stages; simultaneous in/out cancel.
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (in_fire && !out_fire) begin
      count_d = count_q + CountW'(1);
    end else if (out_fire && !in_fire) begin
      count_d = count_q - CountW'(1);
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(STAGES); i++) begin
        data_q[i] <= '0;
      end
      parity_q <= '0;
      valid_q  <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < int'(STAGES); i++) begin
        data_q[i] <= data_d[i];
      end
      parity_q <= parity_d;
      valid_q  <= valid_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_filter_pipe.sv
// Directed bench for filter_pipe (DATA_WIDTH=16, STAGES=2).
// Inputs are driven 1 time unit after the rising edge; outputs are checked there too.

module tb_filter_pipe;

  localparam int unsigned DW = 16;
  localparam int unsigned ST = 2;
  localparam int unsigned CW = $clog2(ST + 1);

  logic          clk;
  logic          reset;
  logic [DW-1:0] x_data;
  logic          x_parity;
  logic          x_valid;
  logic          x_ready;
  logic [DW-1:0] y_data;
  logic          y_parity;
  logic          y_valid;
  logic          y_ready;
  logic [CW-1:0] count;
`ifdef FILTER_PIPE_FLUSH_EN
  logic          flush;
`endif

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] exp_d [10];
  logic          exp_p [10];
  logic [DW:0]   r;

  filter_pipe #(
    .DATA_WIDTH (DW),
    .STAGES     (ST)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .io_x_data   (x_data),
    .io_x_parity (x_parity),
    .io_x_valid  (x_valid),
    .io_x_ready  (x_ready),
    .io_y_data   (y_data),
    .io_y_parity (y_parity),
    .io_y_valid  (y_valid),
    .io_y_ready  (y_ready),
`ifdef FILTER_PIPE_FLUSH_EN
    .io_flush    (flush),
`endif
    .io_count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got running want finished");
    $fatal(1, "timeout");
  end

  // Reference: rotate the 17-bit word {d, p} left by two.
  function automatic logic [DW:0] rot2(input logic [DW-1:0] d, input logic p);
    logic [DW:0] w;
    w = {d, p};
    return (w << 2) | (w >> (DW - 1));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    x_data   = '0;
    x_parity = 1'b0;
    x_valid  = 1'b0;
    y_ready  = 1'b0;
`ifdef FILTER_PIPE_FLUSH_EN
    flush    = 1'b0;
`endif
    #3;
    chk("rst_y_valid",  32'(y_valid),  32'h0);
    chk("rst_y_data",   32'(y_data),   32'h0);
    chk("rst_y_parity", 32'(y_parity), 32'h0);
    chk("rst_count",    32'(count),    32'h0);
    chk("rst_x_ready",  32'(x_ready),  32'h1);
    step();
    reset = 1'b0;
    step();

    // Single beat 0x8001/1 -> 0x0007/0
    y_ready  = 1'b1;
    x_data   = 16'h8001;
    x_parity = 1'b1;
    x_valid  = 1'b1;
    #1;
    chk("t1_x_ready", 32'(x_ready), 32'h1);
    step();
    x_valid = 1'b0;
    chk("t1_count1",  32'(count),   32'h1);
    chk("t1_yv_lat",  32'(y_valid), 32'h0);
    step();
    chk("t1_y_valid",  32'(y_valid),  32'h1);
    chk("t1_y_data",   32'(y_data),   32'h0007);
    chk("t1_y_parity", 32'(y_parity), 32'h0);
    step();
    chk("t1_drained", 32'(y_valid), 32'h0);
    chk("t1_count0",  32'(count),   32'h0);

    // Single beat 0xC000/0 -> 0x0001/1
    x_data   = 16'hC000;
    x_parity = 1'b0;
    x_valid  = 1'b1;
    step();
    x_valid = 1'b0;
    step();
    chk("t2_y_valid",  32'(y_valid),  32'h1);
    chk("t2_y_data",   32'(y_data),   32'h0001);
    chk("t2_y_parity", 32'(y_parity), 32'h1);
    step();

    // Back-to-back stream of 10 beats
    for (int k = 0; k < 10; k++) begin
      r        = rot2(16'(k * 16'h1357 + 16'h0F0F), k[0]);
      exp_d[k] = r[DW:1];
      exp_p[k] = r[0];
    end
    for (int k = 0; k <= 10; k++) begin
      if (k < 10) begin
        x_data   = 16'(k * 16'h1357 + 16'h0F0F);
        x_parity = k[0];
        x_valid  = 1'b1;
      end else begin
        x_valid = 1'b0;
      end
      step();
      if (k >= 1) begin
        chk($sformatf("t3_valid%0d", k - 1),  32'(y_valid),  32'h1);
        chk($sformatf("t3_data%0d", k - 1),   32'(y_data),   32'(exp_d[k-1]));
        chk($sformatf("t3_parity%0d", k - 1), 32'(y_parity), 32'(exp_p[k-1]));
      end
      if (k >= 1 && k <= 9) begin
        chk($sformatf("t3_count%0d", k), 32'(count), 32'h2);
      end
    end
    step();
    chk("t3_empty", 32'(y_valid), 32'h0);
    chk("t3_count", 32'(count),   32'h0);

    // Back-pressure: three beats with consumer stalled
    y_ready  = 1'b0;
    x_data   = 16'hA5A5;
    x_parity = 1'b1;
    x_valid  = 1'b1;
    #1;
    chk("t4_rdyA", 32'(x_ready), 32'h1);
    step();
    x_data   = 16'h0F0F;
    x_parity = 1'b0;
    #1;
    chk("t4_rdyB", 32'(x_ready), 32'h1);
    step();
    x_data   = 16'hFFFF;
    x_parity = 1'b0;
    #1;
    chk("t4_full_rdy", 32'(x_ready), 32'h0);
    chk("t4_count2",   32'(count),   32'h2);
    chk("t4_A_data",   32'(y_data),  32'h9697);
    chk("t4_A_par",    32'(y_parity), 32'h0);
    step();
    chk("t4_hold_data", 32'(y_data),  32'h9697);
    chk("t4_hold_vld",  32'(y_valid), 32'h1);
    chk("t4_hold_cnt",  32'(count),   32'h2);
    y_ready = 1'b1;
    #1;
    chk("t4_rdy_thru", 32'(x_ready), 32'h1);
    step();
    x_valid = 1'b0;
    r = rot2(16'h0F0F, 1'b0);
    chk("t4_B_data", 32'(y_data), 32'(r[DW:1]));
    chk("t4_B_par",  32'(y_parity), 32'(r[0]));
    chk("t4_cnt_eq", 32'(count),  32'h2);
    step();
    r = rot2(16'hFFFF, 1'b0);
    chk("t4_C_data", 32'(y_data), 32'(r[DW:1]));
    chk("t4_C_par",  32'(y_parity), 32'(r[0]));
    chk("t4_cnt1",   32'(count),  32'h1);
    step();
    chk("t4_empty", 32'(y_valid), 32'h0);

    // Reset mid-stream with the pipe full
    y_ready  = 1'b0;
    x_data   = 16'h5555;
    x_parity = 1'b1;
    x_valid  = 1'b1;
    step();
    step();
    chk("t5_full", 32'(count), 32'h2);
    x_valid = 1'b0;
    reset   = 1'b1;
    #1;
    chk("t5_y_valid", 32'(y_valid),  32'h0);
    chk("t5_y_data",  32'(y_data),   32'h0);
    chk("t5_y_par",   32'(y_parity), 32'h0);
    chk("t5_count",   32'(count),    32'h0);
    chk("t5_x_ready", 32'(x_ready),  32'h1);
    step();
    reset    = 1'b0;
    y_ready  = 1'b1;
    x_data   = 16'h1234;
    x_parity = 1'b0;
    x_valid  = 1'b1;
    step();
    x_valid = 1'b0;
    chk("t5_no_stale", 32'(y_valid), 32'h0);
    step();
    chk("t5_valid", 32'(y_valid),  32'h1);
    chk("t5_data",  32'(y_data),   32'h48D0);
    chk("t5_par",   32'(y_parity), 32'h0);
    step();

`ifdef FILTER_PIPE_FLUSH_EN
    // Flush while full with a pending input beat
    y_ready  = 1'b0;
    x_data   = 16'h3C3C;
    x_parity = 1'b0;
    x_valid  = 1'b1;
    step();
    step();
    chk("t6_full", 32'(count), 32'h2);
    y_ready = 1'b1;
    flush   = 1'b1;
    #1;
    chk("t6_x_ready", 32'(x_ready), 32'h0);
    chk("t6_y_valid", 32'(y_valid), 32'h0);
    step();
    flush   = 1'b0;
    x_valid = 1'b0;
    #1;
    chk("t6_count", 32'(count),   32'h0);
    chk("t6_empty", 32'(y_valid), 32'h0);
    step();
    chk("t6_no_stale", 32'(y_valid), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
